// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM states,
// fault codes and default widths.
package pc_seq_pkg;

   localparam int unsigned PC_W_DEF        = 12;
   localparam int unsigned STACK_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      RUN   = 2'b01,
      FAULT = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE = 2'b00,
      FC_OVF  = 2'b01,
      FC_UNF  = 2'b10,
      FC_ILL  = 2'b11
   } fault_code_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential, jump/call target,
// return address from the stack, or taken relative branch.
module pc_next_mux
   import pc_seq_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] target,
   input  logic [PC_W-1:0] branch_offset,
   input  logic [PC_W-1:0] stack_pop_data,
   input  logic            is_jump,
   input  logic            is_call,
   input  logic            is_ret,
   input  logic            is_branch,
   input  logic            branch_taken,
   output logic [PC_W-1:0] pc_plus1,
   output logic [PC_W-1:0] next_pc
);

   // Priority select; the offset is already PC_W wide, so sign extension
   // is implicit and the sum wraps modulo 2^PC_W.
   always_comb begin
      pc_plus1 = pc + PC_W'(1);
      next_pc  = pc_plus1;
      if (is_jump || is_call) begin
         next_pc = target;
      end else if (is_ret) begin
         next_pc = stack_pop_data;
      end else if (is_branch && branch_taken) begin
         next_pc = pc_plus1 + branch_offset;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer in front of the return-address stack.
// Tracks call depth so the stack is never pushed full or popped empty.
// Optional macro TRAP_VECTOR_EN: overflow/underflow redirect to TRAP_ADDR
// with a one-cycle fault pulse instead of halting.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned     PC_W        = PC_W_DEF,
   parameter int unsigned     STACK_DEPTH = STACK_DEPTH_DEF,
   parameter logic [PC_W-1:0] RESET_ADDR  = 12'h000,
   parameter logic [PC_W-1:0] TRAP_ADDR   = 12'hFF0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            is_jump,
   input  logic            is_call,
   input  logic            is_ret,
   input  logic            is_branch,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] target,
   input  logic [PC_W-1:0] branch_offset,
   input  logic [PC_W-1:0] stack_pop_data,
   input  logic            stack_overflow,
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            stack_push,
   output logic            stack_pop,
   output logic [PC_W-1:0] stack_push_data,
   output logic [3:0]      depth,
   output logic            fault,
   output logic [1:0]      fault_code
);

   localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

   state_t          state;
   fault_code_t     fault_code_q;
   logic [PC_W-1:0] next_pc;
   logic [PC_W-1:0] pc_plus1;
   logic            active;
   logic            err_ill;
   logic            err_ovf;
   logic            err_unf;
   logic            err_flag;
   logic            any_err;
   fault_code_t     err_code;

   pc_next_mux #(
      .PC_W(PC_W)
   ) u_next (
      .pc             (pc),
      .target         (target),
      .branch_offset  (branch_offset),
      .stack_pop_data (stack_pop_data),
      .is_jump        (is_jump),
      .is_call        (is_call),
      .is_ret         (is_ret),
      .is_branch      (is_branch),
      .branch_taken   (branch_taken),
      .pc_plus1       (pc_plus1),
      .next_pc        (next_pc)
   );

   // Error detection and stack strobes; any error suppresses both strobes.
   always_comb begin
      active   = (state == RUN) && !stall;
      err_ill  = ($countones({is_jump, is_call, is_ret, is_branch}) > 1);
      err_ovf  = is_call && (depth == DEPTH_MAX);
      err_unf  = is_ret && (depth == 4'd0);
      err_flag = stack_overflow;
      any_err  = err_ill || err_ovf || err_unf || err_flag;
      if (err_ill) begin
         err_code = FC_ILL;
      end else if (err_ovf) begin
         err_code = FC_OVF;
      end else if (err_unf) begin
         err_code = FC_UNF;
      end else if (err_flag) begin
         err_code = FC_OVF;
      end else begin
         err_code = FC_NONE;
      end
      stack_push      = active && !any_err && is_call;
      stack_pop       = active && !any_err && is_ret;
      stack_push_data = pc_plus1;
   end

   assign fault_code = fault_code_q;

   // Sequencer FSM with PC, depth and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= BOOT;
         pc           <= RESET_ADDR;
         depth        <= '0;
         fetch_valid  <= 1'b0;
         fault        <= 1'b0;
         fault_code_q <= FC_NONE;
      end else begin
         case (state)
            BOOT: begin
               if (!stall) begin
                  state       <= RUN;
                  fetch_valid <= 1'b1;
               end
            end
            RUN: begin
               fault <= 1'b0;
               if (!stall) begin
                  if (any_err) begin
                     fault        <= 1'b1;
                     fault_code_q <= err_code;
`ifdef TRAP_VECTOR_EN
                     if (err_ill) begin
                        state       <= FAULT;
                        fetch_valid <= 1'b0;
                     end else begin
                        pc <= TRAP_ADDR;
                     end
`else
                     state       <= FAULT;
                     fetch_valid <= 1'b0;
`endif
                  end else begin
                     pc <= next_pc;
                     if (is_call) begin
                        depth <= depth + 4'd1;
                     end else if (is_ret) begin
                        depth <= depth - 4'd1;
                     end
                  end
               end
            end
            FAULT: begin
               fetch_valid <= 1'b0;
            end
            default: begin
               state       <= FAULT;
               fetch_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
